// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback over a shared memory.
// Optional bne support is compiled in with `define MIPS_MC_BNE_EN.
module mips_multicycle_ctrl #(
    parameter int MAX_WAIT = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] Op,
    input  logic [5:0] Funct,
    input  logic       Zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       IorD,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       PCEn,
    output logic [1:0] PCSrc,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUControl,
    output logic       instr_done,
    output logic       illegal_op,
    output logic       mem_fault
);

    localparam int CW = $clog2(MAX_WAIT + 1);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
`ifdef MIPS_MC_BNE_EN
    localparam logic [5:0] OP_BNE   = 6'b000101;
`endif

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE, S_EXECUTE,
        S_ALUWB, S_BRANCH, S_ADDIEX, S_ADDIWB, S_JUMP, S_FAULT
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] wait_q, wait_d;
    logic          fault_q, fault_d;
`ifdef MIPS_MC_BNE_EN
    logic          bne_q, bne_d;
`endif

    function automatic logic funct_legal(input logic [5:0] f);
        return (f == 6'b100000) || (f == 6'b100010) || (f == 6'b100100) ||
               (f == 6'b100101) || (f == 6'b101010);
    endfunction

    function automatic logic [2:0] funct_alu(input logic [5:0] f);
        case (f)
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default:   return 3'b010;
        endcase
    endfunction

    always_comb begin
        state_d    = state_q;
        wait_d     = '0;
        fault_d    = fault_q;
`ifdef MIPS_MC_BNE_EN
        bne_d      = bne_q;
`endif
        mem_req    = 1'b0;
        IorD       = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        PCEn       = 1'b0;
        PCSrc      = 2'b00;
        RegDst     = 1'b0;
        MemtoReg   = 1'b0;
        RegWrite   = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        ALUControl = 3'b010;
        instr_done = 1'b0;
        illegal_op = 1'b0;

        case (state_q)
            S_FETCH: begin
                mem_req = 1'b1;
                ALUSrcB = 2'b01;
                IRWrite = mem_ready;
                PCEn    = mem_ready;
                if (mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                // Branch target computed now so BRANCH only needs the compare.
                ALUSrcB = 2'b11;
`ifdef MIPS_MC_BNE_EN
                bne_d   = (Op == OP_BNE);
`endif
                case (Op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE: begin
                        if (funct_legal(Funct)) begin
                            state_d = S_EXECUTE;
                        end else begin
                            illegal_op = 1'b1;
                            state_d    = S_FETCH;
                        end
                    end
                    OP_BEQ:  state_d = S_BRANCH;
`ifdef MIPS_MC_BNE_EN
                    OP_BNE:  state_d = S_BRANCH;
`endif
                    OP_ADDI: state_d = S_ADDIEX;
                    OP_J:    state_d = S_JUMP;
                    default: begin
                        illegal_op = 1'b1;
                        state_d    = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                state_d = (Op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                mem_req = 1'b1;
                IorD    = 1'b1;
                if (mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                MemtoReg   = 1'b1;
                RegWrite   = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWRITE: begin
                mem_req  = 1'b1;
                IorD     = 1'b1;
                MemWrite = 1'b1;
                if (mem_ready) begin
                    instr_done = 1'b1;
                    state_d    = S_FETCH;
                end
            end
            S_EXECUTE: begin
                ALUSrcA    = 1'b1;
                ALUControl = funct_alu(Funct);
                state_d    = S_ALUWB;
            end
            S_ALUWB: begin
                RegDst     = 1'b1;
                RegWrite   = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA    = 1'b1;
                ALUControl = 3'b110;
                PCSrc      = 2'b01;
`ifdef MIPS_MC_BNE_EN
                PCEn       = bne_q ? ~Zero : Zero;
`else
                PCEn       = Zero;
`endif
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_ADDIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                state_d = S_ADDIWB;
            end
            S_ADDIWB: begin
                RegWrite   = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_JUMP: begin
                PCSrc      = 2'b10;
                PCEn       = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_FAULT: state_d = S_FAULT;
            default: state_d = S_FETCH;
        endcase

        // A stalled access that has already waited MAX_WAIT cycles gives up; ready on that cycle still wins.
        if (mem_req && !mem_ready) begin
            if (wait_q == CW'(MAX_WAIT)) begin
                state_d = S_FAULT;
                fault_d = 1'b1;
            end else begin
                wait_d = wait_q + 1'b1;
            end
        end

        if (reset) begin
            mem_req    = 1'b0;
            MemWrite   = 1'b0;
            IRWrite    = 1'b0;
            PCEn       = 1'b0;
            RegWrite   = 1'b0;
            instr_done = 1'b0;
            illegal_op = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
            wait_q  <= '0;
            fault_q <= 1'b0;
`ifdef MIPS_MC_BNE_EN
            bne_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            fault_q <= fault_d;
`ifdef MIPS_MC_BNE_EN
            bne_q   <= bne_d;
`endif
        end
    end

    assign mem_fault = fault_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Bench for mips_multicycle_ctrl: instruction table, timeline-model random run, fault/reset sequences.
module tb_mips_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] Op, Funct;
    logic       Zero, mem_ready;
    logic       mem_req, IorD, MemWrite, IRWrite, PCEn, RegDst, MemtoReg, RegWrite, ALUSrcA;
    logic       instr_done, illegal_op, mem_fault;
    logic [1:0] PCSrc, ALUSrcB;
    logic [2:0] ALUControl;

    mips_multicycle_ctrl #(.MAX_WAIT(15)) dut (
        .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .Zero(Zero), .mem_ready(mem_ready),
        .mem_req(mem_req), .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite), .PCEn(PCEn),
        .PCSrc(PCSrc), .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUControl(ALUControl),
        .instr_done(instr_done), .illegal_op(illegal_op), .mem_fault(mem_fault)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    localparam int K_LW = 0, K_SW = 1, K_R = 2, K_BEQ = 3, K_ADDI = 4, K_J = 5, K_ILL = 6, K_BNE = 7;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [6:0] strobes();
        return {mem_req, MemWrite, IRWrite, PCEn, RegWrite, instr_done, illegal_op};
    endfunction

    function automatic int classify(input logic [5:0] op, input logic [5:0] f);
        case (op)
            6'h23: return K_LW;
            6'h2b: return K_SW;
            6'h00: return (f == 6'h20 || f == 6'h22 || f == 6'h24 || f == 6'h25 || f == 6'h2a) ? K_R : K_ILL;
            6'h04: return K_BEQ;
            6'h08: return K_ADDI;
            6'h02: return K_J;
`ifdef MIPS_MC_BNE_EN
            6'h05: return K_BNE;
`endif
            default: return K_ILL;
        endcase
    endfunction

    function automatic logic [2:0] alu_of(input logic [5:0] f);
        case (f)
            6'h22: return 3'b110;
            6'h24: return 3'b000;
            6'h25: return 3'b001;
            6'h2a: return 3'b111;
            default: return 3'b010;
        endcase
    endfunction

    task automatic cyc(input logic rst, input logic rdy);
        @(posedge clk);
        #1;
        reset     = rst;
        mem_ready = rdy;
        #1;
    endtask

    // Drives one instruction from FETCH: fetch waits d0 cycles, data access waits d1 cycles.
    // Expected strobes come from a per-cycle timeline built from the instruction latencies.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] f, input logic z,
                             input int d0, input int d1,
                             output int end_c, output int rw_cnt, output int mw_cnt,
                             output int pc_cnt, output int done_cnt);
        int  kind, len, w2s, w2e, last;
        bit  has2, in1, in2, taken;
        logic [6:0] exp;
        kind  = classify(op, f);
        has2  = (kind == K_LW) || (kind == K_SW);
        w2s   = d0 + 3;
        w2e   = d0 + 3 + d1;
        case (kind)
            K_LW:         len = d0 + d1 + 5;
            K_SW:         len = d0 + d1 + 4;
            K_R, K_ADDI:  len = d0 + 4;
            K_ILL:        len = d0 + 2;
            default:      len = d0 + 3;
        endcase
        last  = len - 1;
        taken = (kind == K_J) || (kind == K_BEQ && z) || (kind == K_BNE && !z);
        end_c = -1; rw_cnt = 0; mw_cnt = 0; pc_cnt = 0; done_cnt = 0;
        for (int c = 0; c < len; c++) begin
            in1 = (c <= d0);
            in2 = has2 && (c >= w2s) && (c <= w2e);
            @(posedge clk);
            #1;
            reset = 1'b0;
            Op = op; Funct = f; Zero = z;
            mem_ready = in1 ? (c == d0) : in2 ? (c == w2e) : 1'($urandom_range(0, 1));
            #1;
            exp = {1'(in1 || in2),
                   1'(in2 && kind == K_SW),
                   1'(c == d0),
                   1'(c == d0 || (c == last && taken)),
                   1'(c == last && (kind == K_LW || kind == K_R || kind == K_ADDI)),
                   1'(c == last && kind != K_ILL),
                   1'(kind == K_ILL && c == d0 + 1)};
            chk($sformatf("strobes op=%h c=%0d", op, c), strobes(), exp);
            if (in1) chk("fetch_mux", {IorD, ALUSrcB}, 3'b001);
            if (in2) chk("data_addr", IorD, 1'b1);
            if (c == last && (kind == K_LW || kind == K_R || kind == K_ADDI))
                chk("wb_mux", {RegDst, MemtoReg}, {1'(kind == K_R), 1'(kind == K_LW)});
            if (kind == K_R && c == d0 + 2) chk("alu_exec", ALUControl, alu_of(f));
            if ((kind == K_BEQ || kind == K_BNE) && c == last) chk("branch_mux", {PCSrc, ALUControl}, 5'b01110);
            if (kind == K_J && c == last) chk("jump_src", PCSrc, 2'b10);
            if ((instr_done || illegal_op) && end_c < 0) end_c = c;
            rw_cnt   += int'(RegWrite);
            mw_cnt   += int'(MemWrite);
            pc_cnt   += int'(PCEn);
            done_cnt += int'(instr_done);
        end
        chk("no_fault", mem_fault, 1'b0);
    endtask

    typedef struct {
        logic [5:0] op;
        logic [5:0] funct;
        logic       zero;
        int         cycles;
        int         rw;
        int         mw;
        int         pcen;
        int         done;
    } vec_t;

    vec_t tbl[14];

    initial begin
        int e, rw, mw, pc, dn;
        logic [5:0] ops[8];
        logic [5:0] fns[6];

        tbl[0]  = '{6'h23, 6'h00, 1'b0, 5, 1, 0, 1, 1};
        tbl[1]  = '{6'h2b, 6'h00, 1'b0, 4, 0, 1, 1, 1};
        tbl[2]  = '{6'h00, 6'h20, 1'b0, 4, 1, 0, 1, 1};
        tbl[3]  = '{6'h00, 6'h22, 1'b1, 4, 1, 0, 1, 1};
        tbl[4]  = '{6'h00, 6'h24, 1'b0, 4, 1, 0, 1, 1};
        tbl[5]  = '{6'h00, 6'h25, 1'b0, 4, 1, 0, 1, 1};
        tbl[6]  = '{6'h00, 6'h2a, 1'b0, 4, 1, 0, 1, 1};
        tbl[7]  = '{6'h00, 6'h21, 1'b0, 2, 0, 0, 1, 0};
        tbl[8]  = '{6'h04, 6'h00, 1'b1, 3, 0, 0, 2, 1};
        tbl[9]  = '{6'h04, 6'h00, 1'b0, 3, 0, 0, 1, 1};
        tbl[10] = '{6'h08, 6'h00, 1'b0, 4, 1, 0, 1, 1};
        tbl[11] = '{6'h02, 6'h00, 1'b0, 3, 0, 0, 2, 1};
        tbl[12] = '{6'h3f, 6'h00, 1'b0, 2, 0, 0, 1, 0};
`ifdef MIPS_MC_BNE_EN
        tbl[13] = '{6'h05, 6'h00, 1'b0, 3, 0, 0, 2, 1};
`else
        tbl[13] = '{6'h05, 6'h00, 1'b0, 2, 0, 0, 1, 0};
`endif

        reset = 1'b1; Op = '0; Funct = '0; Zero = 1'b0; mem_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            cyc(1'b1, 1'b1);
            chk("reset_strobes", strobes(), 7'd0);
        end
        chk("reset_fault", mem_fault, 1'b0);

        for (int i = 0; i < 14; i++) begin
            run_instr(tbl[i].op, tbl[i].funct, tbl[i].zero, 0, 0, e, rw, mw, pc, dn);
            chk($sformatf("tbl%0d_cycles", i), e + 1, tbl[i].cycles);
            chk($sformatf("tbl%0d_regwrite", i), rw, tbl[i].rw);
            chk($sformatf("tbl%0d_memwrite", i), mw, tbl[i].mw);
            chk($sformatf("tbl%0d_pcen", i), pc, tbl[i].pcen);
            chk($sformatf("tbl%0d_done", i), dn, tbl[i].done);
        end

        // lw stalled 3 cycles in the data read
        run_instr(6'h23, 6'h00, 1'b0, 0, 3, e, rw, mw, pc, dn);
        chk("lw_wait3_cycles", e + 1, 8);
        chk("lw_wait3_regwrite", rw, 1);

        // ready on the final allowed wait cycle completes normally
        run_instr(6'h00, 6'h20, 1'b0, 15, 0, e, rw, mw, pc, dn);
        chk("ready_wins_cycles", e + 1, 19);
        run_instr(6'h2b, 6'h00, 1'b0, 0, 15, e, rw, mw, pc, dn);
        chk("sw_wait15_memwrite", mw, 16);

        // reset in the middle of a store
        cyc(1'b0, 1'b1);
        Op = 6'h2b;
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b0);
        chk("sw_in_progress", {mem_req, MemWrite}, 2'b11);
        cyc(1'b1, 1'b1);
        chk("mid_reset_strobes", strobes(), 7'd0);
        run_instr(6'h00, 6'h25, 1'b0, 0, 0, e, rw, mw, pc, dn);
        chk("after_mid_reset", e + 1, 4);

        // fetch timeout
        for (int k = 0; k < 16; k++) begin
            cyc(1'b0, 1'b0);
            chk($sformatf("to_wait%0d", k), {mem_req, mem_fault}, 2'b10);
        end
        for (int k = 0; k < 4; k++) begin
            cyc(1'b0, 1'($urandom_range(0, 1)));
            chk($sformatf("fault_sticky%0d", k), mem_fault, 1'b1);
            chk($sformatf("fault_strobes%0d", k), strobes(), 7'd0);
        end
        cyc(1'b1, 1'b1);
        chk("fault_reset_strobes", strobes(), 7'd0);
        run_instr(6'h08, 6'h00, 1'b0, 0, 0, e, rw, mw, pc, dn);
        chk("after_fault_cycles", e + 1, 4);

        ops = '{6'h23, 6'h2b, 6'h00, 6'h04, 6'h08, 6'h02, 6'h05, 6'h00};
        fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a, 6'h20};
        for (int n = 0; n < 200; n++) begin
            logic [5:0] op, f;
            op = ($urandom_range(0, 7) == 0) ? 6'($urandom) : ops[$urandom_range(0, 7)];
            f  = ($urandom_range(0, 5) == 0) ? 6'($urandom) : fns[$urandom_range(0, 5)];
            run_instr(op, f, 1'($urandom_range(0, 1)), $urandom_range(0, 15), $urandom_range(0, 15),
                      e, rw, mw, pc, dn);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
